// File: rtl/dmem_loader_pkg.sv
// Shared constants and state encoding for the data-memory boot/test loader.
package dmem_loader_pkg;

   localparam int unsigned LD_AW = 8;
   localparam int unsigned LD_DW = 8;
   localparam int unsigned LD_LW = LD_AW + 1;

   typedef enum logic [1:0] {
      LD_IDLE,
      LD_LOAD,
      LD_DONE
   } ld_state_t;

endpackage

// File: rtl/dmem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader.
interface dmem_loader_if #(
   parameter int unsigned DW = 8
);

   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/dmem_loader.sv
// Loader upstream of the data memory: passes CPU stores through when idle,
// otherwise holds the CPU and writes a streamed byte block to consecutive addresses.
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int unsigned AW = LD_AW,
   parameter int unsigned DW = LD_DW,
   parameter int unsigned LW = AW + 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [AW-1:0]       base_addr,
   input  logic [LW-1:0]       length,
   dmem_loader_if.slave        stream,
   input  logic [AW-1:0]       cpu_addr,
   input  logic [DW-1:0]       cpu_dat,
   input  logic                cpu_wr_en,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_dat_in,
   output logic                mem_wr_en,
   output logic                cpu_hold,
   output logic                busy,
   output logic                done,
   output logic [DW-1:0]       checksum
);

   localparam logic [LW-1:0] DEPTH = LW'(2 ** AW);

   ld_state_t     state, state_next;
   logic [AW-1:0] base;
   logic [LW-1:0] len;
   logic [LW-1:0] cnt;
   logic [DW-1:0] sum;
   logic          fire;

   assign fire     = (state == LD_LOAD) && stream.in_valid;
   assign checksum = sum;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= LD_IDLE;
         base  <= '0;
         len   <= '0;
         cnt   <= '0;
         sum   <= '0;
      end else begin
         state <= state_next;
         if (state == LD_IDLE && start) begin
            base <= base_addr;
            len  <= (length > DEPTH) ? DEPTH : length;
            cnt  <= '0;
            sum  <= '0;
         end else if (fire) begin
            cnt <= cnt + LW'(1);
            sum <= sum + stream.in_data;
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         LD_IDLE: if (start) state_next = (length == '0) ? LD_DONE : LD_LOAD;
         // cnt+1 == len is the cnt == len-1 test without underflow at len 0
         LD_LOAD: if (fire && (cnt + LW'(1) == len)) state_next = LD_DONE;
         LD_DONE: state_next = LD_IDLE;
         default: state_next = LD_IDLE;
      endcase
   end

   always_comb begin
      mem_addr        = cpu_addr;
      mem_dat_in      = cpu_dat;
      mem_wr_en       = cpu_wr_en;
      stream.in_ready = 1'b0;
      cpu_hold        = (state != LD_IDLE);
      busy            = (state == LD_LOAD);
      done            = (state == LD_DONE);
      case (state)
         LD_IDLE: ;
         LD_LOAD: begin
            mem_addr        = base + cnt[AW-1:0];
            mem_dat_in      = stream.in_data;
            mem_wr_en       = fire;
            stream.in_ready = 1'b1;
         end
         default: mem_wr_en = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_dmem_loader.sv
// Directed self-checking bench for dmem_loader.
module tb_dmem_loader;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] base_addr;
   logic [8:0] length;
   logic [7:0] cpu_addr;
   logic [7:0] cpu_dat;
   logic       cpu_wr_en;
   logic [7:0] mem_addr;
   logic [7:0] mem_dat_in;
   logic       mem_wr_en;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic [7:0] checksum;

   int checks   = 0;
   int failures = 0;
   int wr_count = 0;
   logic [7:0] tbmem [256];

   dmem_loader_if #(.DW(8)) stream ();

   dmem_loader #(.AW(8), .DW(8), .LW(9)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .base_addr  (base_addr),
      .length     (length),
      .stream     (stream),
      .cpu_addr   (cpu_addr),
      .cpu_dat    (cpu_dat),
      .cpu_wr_en  (cpu_wr_en),
      .mem_addr   (mem_addr),
      .mem_dat_in (mem_dat_in),
      .mem_wr_en  (mem_wr_en),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Memory model: commit whatever the write port shows at the coming edge.
   task automatic tick();
      if (mem_wr_en === 1'b1) begin
         tbmem[mem_addr] = mem_dat_in;
         wr_count++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int wr0;
      int sent;
      int nff;
      logic [7:0] exp_sum;

      for (int i = 0; i < 256; i++) tbmem[i] = 8'h00;
      reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
      cpu_addr = '0; cpu_dat = '0; cpu_wr_en = 1'b0;
      stream.in_valid = 1'b0; stream.in_data = '0;
      @(posedge clk); #1;
      tick();
      reset = 1'b0;

      // 1) reset state and pass-through
      cpu_wr_en = 1'b1; cpu_addr = 8'h10; cpu_dat = 8'h5A; #1;
      chk("rst_cpu_hold", cpu_hold, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", stream.in_ready, 0);
      chk("rst_checksum", checksum, 8'h00);
      chk("idle_mem_addr", mem_addr, 8'h10);
      chk("idle_mem_dat", mem_dat_in, 8'h5A);
      chk("idle_mem_wr", mem_wr_en, 1);
      tick();

      // 2) base 0x20, 4 back-to-back bytes; CPU store in start cycle passes
      start = 1'b1; base_addr = 8'h20; length = 9'd4;
      cpu_addr = 8'h33; cpu_dat = 8'h77; #1;
      chk("start_cycle_cpu_addr", mem_addr, 8'h33);
      chk("start_cycle_cpu_wr", mem_wr_en, 1);
      tick();
      start = 1'b0; base_addr = 8'h99; length = 9'd1;
      exp_sum = 8'h00;
      for (int i = 0; i < 4; i++) begin
         stream.in_valid = 1'b1; stream.in_data = 8'(i + 1); #1;
         chk("t2_in_ready", stream.in_ready, 1);
         chk("t2_busy", busy, 1);
         chk("t2_hold", cpu_hold, 1);
         chk("t2_done_low", done, 0);
         chk("t2_mem_wr", mem_wr_en, 1);
         chk("t2_mem_addr", mem_addr, 32'(8'h20 + i));
         chk("t2_mem_dat", mem_dat_in, 32'(i + 1));
         chk("t2_partial_sum", checksum, exp_sum);
         exp_sum = exp_sum + 8'(i + 1);
         tick();
      end
      stream.in_valid = 1'b0; #1;
      chk("t2_done", done, 1);
      chk("t2_done_busy", busy, 0);
      chk("t2_done_hold", cpu_hold, 1);
      chk("t2_done_in_ready", stream.in_ready, 0);
      chk("t2_done_wr_blocked", mem_wr_en, 0);
      chk("t2_checksum", checksum, 8'h0A);
      tick();
      chk("t2_done_pulse_end", done, 0);
      chk("t2_hold_release", cpu_hold, 0);
      chk("t2_checksum_held", checksum, 8'h0A);
      chk("t2_cpu_passthru_back", mem_wr_en, 1);
      cpu_wr_en = 1'b0;
      for (int i = 0; i < 4; i++) chk("t2_mem_content", tbmem[8'h20 + i], 32'(i + 1));
      chk("t2_cpu_store_mem", tbmem[8'h33], 8'h77);

      // 3) base 0xFE wraps, in_valid every other cycle
      start = 1'b1; base_addr = 8'hFE; length = 9'd4; #1;
      tick();
      start = 1'b0;
      wr0 = wr_count; sent = 0;
      for (int k = 0; k < 7; k++) begin
         stream.in_valid = (k % 2 == 0);
         stream.in_data  = stream.in_valid ? 8'(8'hA0 + sent) : 8'h55;
         #1;
         chk("t3_mem_wr", mem_wr_en, stream.in_valid);
         chk("t3_mem_addr", mem_addr, 32'(8'(8'hFE + sent)));
         tick();
         if (k % 2 == 0) sent++;
      end
      stream.in_valid = 1'b0; #1;
      chk("t3_done", done, 1);
      chk("t3_checksum", checksum, 8'h86);
      chk("t3_write_count", wr_count - wr0, 4);
      chk("t3_mem_fe", tbmem[8'hFE], 8'hA0);
      chk("t3_mem_ff", tbmem[8'hFF], 8'hA1);
      chk("t3_mem_00", tbmem[8'h00], 8'hA2);
      chk("t3_mem_01", tbmem[8'h01], 8'hA3);
      chk("t3_mem_02_untouched", tbmem[8'h02], 8'h00);
      tick();

      // 4) zero length
      start = 1'b1; base_addr = 8'h40; length = 9'd0; #1;
      tick();
      start = 1'b0; stream.in_valid = 1'b1; stream.in_data = 8'hEE;
      wr0 = wr_count; #1;
      chk("t4_done", done, 1);
      chk("t4_busy", busy, 0);
      chk("t4_in_ready", stream.in_ready, 0);
      chk("t4_mem_wr", mem_wr_en, 0);
      chk("t4_checksum", checksum, 8'h00);
      tick();
      chk("t4_done_end", done, 0);
      chk("t4_hold", cpu_hold, 0);
      chk("t4_idle_in_ready", stream.in_ready, 0);
      chk("t4_no_writes", wr_count - wr0, 0);
      stream.in_valid = 1'b0;

      // 5) reset mid-LOAD; start during LOAD ignored
      start = 1'b1; base_addr = 8'h80; length = 9'd8; #1;
      tick();
      stream.in_valid = 1'b1; stream.in_data = 8'h11;
      base_addr = 8'h00; length = 9'd1; #1;
      chk("t5_addr0", mem_addr, 8'h80);
      tick();
      start = 1'b0; stream.in_data = 8'h22; #1;
      chk("t5_addr1_no_restart", mem_addr, 8'h81);
      chk("t5_busy", busy, 1);
      tick();
      stream.in_valid = 1'b0; #1;
      chk("t5_partial_checksum", checksum, 8'h33);
      chk("t5_still_loading", busy, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0; #1;
      chk("t5_abort_busy", busy, 0);
      chk("t5_abort_hold", cpu_hold, 0);
      chk("t5_abort_done", done, 0);
      chk("t5_abort_checksum", checksum, 8'h00);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_done", done, 0);
      end
      chk("t5_bytes_kept", tbmem[8'h81], 8'h22);

      // 6) length 300 clamps to 256, all 0xFF
      start = 1'b1; base_addr = 8'h10; length = 9'd300; #1;
      tick();
      start = 1'b0;
      wr0 = wr_count;
      stream.in_valid = 1'b1; stream.in_data = 8'hFF;
      for (int i = 0; i < 256; i++) begin
         #1;
         chk("t6_mem_wr", mem_wr_en, 1);
         chk("t6_mem_addr", mem_addr, 32'(8'(8'h10 + i)));
         tick();
      end
      stream.in_valid = 1'b0; #1;
      chk("t6_done", done, 1);
      chk("t6_checksum", checksum, 8'h00);
      chk("t6_write_count", wr_count - wr0, 256);
      nff = 0;
      for (int i = 0; i < 256; i++) if (tbmem[i] == 8'hFF) nff++;
      chk("t6_all_ff", nff, 256);
      tick();
      chk("t6_idle", cpu_hold, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
